// File: rtl/exe_pkg.sv
// -----------------------------------------------------------------------------
// exe_pkg
//   Definitions shared by the EXE-stage blocks: the MUL command encoding,
//   the multiply sequencer state type and a helper that derives the number of
//   shift-add iterations from the operand width and bits retired per cycle.
// -----------------------------------------------------------------------------
package exe_pkg;

   // exe_cmd encoding that decode assigns to MUL.
   localparam logic [3:0] EXE_CMD_MUL = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   // Number of RUN cycles needed to retire every multiplier bit.
   function automatic int mul_iter(input int width, input int bpc);
      return width / bpc;
   endfunction

endpackage

// File: rtl/mul_step.sv
// -----------------------------------------------------------------------------
// mul_step
//   One shift-add step of the iterative multiplier (purely combinational).
//   Ports:
//     acc          in   WIDTH  running partial product
//     mcand        in   WIDTH  multiplicand, already shifted to this step's weight
//     mplier_slice in   BPC    multiplier bits retired in this step
//     acc_next     out  WIDTH  acc + mcand * mplier_slice, modulo 2^WIDTH
// -----------------------------------------------------------------------------
module mul_step #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] mcand,
   input  logic [BPC-1:0]   mplier_slice,
   output logic [WIDTH-1:0] acc_next
);

   logic [WIDTH-1:0] partial;

   // Only the low WIDTH bits of the product are kept, so the partial product
   // and the sum are both truncated to WIDTH.
   always_comb begin
      partial  = mcand * WIDTH'(mplier_slice);
      acc_next = acc + partial;
   end

endmodule

// File: rtl/exe_mul_sequencer.sv
// -----------------------------------------------------------------------------
// exe_mul_sequencer
//   Multi-cycle MUL controller for the EXE stage. Computes the low WIDTH bits
//   of op_a * op_b by iterative shift-add, freezes IF/ID/EXE while working and
//   presents the product and N/Z flags for exactly one release cycle (DONE).
//   Ports:
//     clk           in   1      rising-edge clock
//     rst           in   1      asynchronous reset, active-low
//     in_valid      in   1      valid instruction in EXE
//     is_mul        in   1      decoded exe_cmd is MUL
//     s_bit         in   1      instruction updates the status register
//     flush         in   1      branch taken / pipeline flush
//     op_a          in   WIDTH  multiplicand
//     op_b          in   WIDTH  multiplier
//     sr            in   4      current {N,Z,C,V}
//     stall         out  1      freeze IF/ID/EXE registers
//     busy          out  1      sequencer not idle
//     result        out  WIDTH  product, low WIDTH bits (held until next start)
//     result_valid  out  1      result usable this cycle
//     status        out  4      {N,Z,C,V} to write back (zero outside DONE)
//     status_we     out  1      status write enable
// -----------------------------------------------------------------------------
module exe_mul_sequencer
   import exe_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int BPC        = 1,
   parameter int EARLY_EXIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             is_mul,
   input  logic             s_bit,
   input  logic             flush,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       sr,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [3:0]       status,
   output logic             status_we
);

   localparam int               ITER     = mul_iter(WIDTH, BPC);
   localparam int               CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

   mul_state_t       state_q,  state_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;

   logic             start;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] mplier_shift;

   // N and Z are recomputed from the product; only C and V pass through.
   logic unused_sr_nz;
   assign unused_sr_nz = ^sr[3:2];

   mul_step #(
      .WIDTH (WIDTH),
      .BPC   (BPC)
   ) u_mul_step (
      .acc          (acc_q),
      .mcand        (mcand_q),
      .mplier_slice (mplier_q[BPC-1:0]),
      .acc_next     (acc_step)
   );

   // NOTE: every register is reset, including the datapath, so that result
   // and status read as zero while rst is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a variable
      // unassigned and infers a latch.
      state_d      = state_q;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      cnt_d        = cnt_q;
      result_valid = 1'b0;
      status_we    = 1'b0;

      // rst gates start so stall is low during reset even with a MUL in EXE.
      start        = rst & in_valid & is_mul & ~flush & (state_q == IDLE);
      stall        = start;
      mplier_shift = mplier_q >> BPC;

      case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
               // A zero multiplier has nothing to accumulate.
               state_d  = (EARLY_EXIT != 0 && op_b == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (flush) begin
               // Squashed instruction: abandon the product, release at once.
               state_d = IDLE;
            end else begin
               stall    = 1'b1;
               acc_d    = acc_step;
               mcand_d  = mcand_q << BPC;
               mplier_d = mplier_shift;
               cnt_d    = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST || (EARLY_EXIT != 0 && mplier_shift == '0)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            // The instruction still sitting in EXE is the one just finished;
            // in_valid is ignored here and the pipeline advances this cycle.
            result_valid = ~flush;
            status_we    = s_bit & ~flush;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign result = acc_q;
   assign status = (state_q == DONE) ? {acc_q[WIDTH-1], (acc_q == '0), sr[1], sr[0]} : 4'b0000;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exe_mul_sequencer
//   Three sequencer instances (BPC=1 no early exit, BPC=1 early exit, BPC=4 no
//   early exit), each with its own stimulus. Expected product, flags and
//   latency come from plain arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_exe_mul_sequencer;

   localparam int N = 3;
   localparam int BPC_T [N] = '{1, 1, 4};
   localparam int EE_T  [N] = '{0, 1, 0};

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  in_valid, is_mul, s_bit, flush;
   logic [N-1:0]  stall, busy, result_valid, status_we;
   logic [31:0]   op_a   [N];
   logic [31:0]   op_b   [N];
   logic [31:0]   result [N];
   logic [3:0]    sr     [N];
   logic [3:0]    status [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      exe_mul_sequencer #(
         .WIDTH      (32),
         .BPC        (BPC_T[g]),
         .EARLY_EXIT (EE_T[g])
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .in_valid     (in_valid[g]),
         .is_mul       (is_mul[g]),
         .s_bit        (s_bit[g]),
         .flush        (flush[g]),
         .op_a         (op_a[g]),
         .op_b         (op_b[g]),
         .sr           (sr[g]),
         .stall        (stall[g]),
         .busy         (busy[g]),
         .result       (result[g]),
         .result_valid (result_valid[g]),
         .status       (status[g]),
         .status_we    (status_we[g])
      );
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Cycles from start to DONE: one per BPC-bit chunk that must be retired,
   // plus one for DONE itself.
   function automatic int exp_latency(input logic [31:0] b, input int bpc, input int ee);
      int bits;
      bits = 0;
      if (ee == 0) return 32 / bpc + 1;
      for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
      return (bits + bpc - 1) / bpc + 1;
   endfunction

   task automatic drive_cmd(input int k, input logic [3:0] cmd, input logic [31:0] a,
                            input logic [31:0] b, input logic s, input logic [3:0] srv);
      in_valid[k] = 1'b1;
      is_mul[k]   = (cmd == exe_pkg::EXE_CMD_MUL);
      op_a[k]     = a;
      op_b[k]     = b;
      s_bit[k]    = s;
      sr[k]       = srv;
      flush[k]    = 1'b0;
   endtask

   // Issues a MUL on instance k in the current cycle (cycle 0) and follows it
   // to completion. flush_at >= 1 asserts flush during that cycle.
   task automatic do_mul(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [3:0] srv, input int flush_at);
      int          lat;
      logic [31:0] p;
      logic        fl;
      lat = exp_latency(b, BPC_T[k], EE_T[k]);
      p   = a * b;
      drive_cmd(k, exe_pkg::EXE_CMD_MUL, a, b, s, srv);
      #1;
      check("start_cycle", {busy[k], stall[k], result_valid[k]}, 3'b010);
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk);
         #1;
         fl = (c == flush_at);
         if (fl) begin
            flush[k] = 1'b1;
            #1;
         end
         if (c < lat) begin
            if (fl) begin
               check("flush_run", {busy[k], stall[k], result_valid[k]}, 3'b100);
               @(posedge clk);
               #1;
               flush[k]    = 1'b0;
               in_valid[k] = 1'b0;
               #1;
               check("flush_idle", {busy[k], stall[k], result_valid[k], status_we[k]}, 4'b0000);
               return;
            end
            check("run_cycle", {busy[k], stall[k], result_valid[k]}, 3'b110);
         end else begin
            check("done_flags", {busy[k], stall[k], result_valid[k], status_we[k]},
                  {1'b1, 1'b0, ~fl, s & ~fl});
            if (!fl) begin
               check("done_result", result[k], p);
               check("done_status", status[k], {p[31], (p == 32'd0), srv[1:0]});
            end
         end
      end
      in_valid[k] = 1'b0;
      flush[k]    = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      logic [31:0] ra, rb;
      rst      = 1'b0;
      in_valid = '0;
      is_mul   = '0;
      s_bit    = '0;
      flush    = '0;
      for (int k = 0; k < N; k++) begin
         op_a[k] = '0;
         op_b[k] = '0;
         sr[k]   = '0;
      end

      // Reset state.
      #3;
      check("reset_ctrl", {stall, busy, result_valid, status_we}, '0);
      check("reset_data", {result[0], status[0], result[2], status[2]}, '0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();

      // 7 * 6 with full latency, C and V copied from sr.
      do_mul(0, 32'd7, 32'd6, 1'b1, 4'b1111, -1);
      next_cycle();
      check("result_held", result[0], 32'd42);
      check("status_idle", status[0], 4'b0000);

      // Wraparound with negative result.
      do_mul(0, 32'hFFFF_FFFF, 32'd2, 1'b1, 4'b0010, -1);
      next_cycle();

      // Early exit: zero multiplier, then short multiplier.
      do_mul(1, 32'd99, 32'd0, 1'b1, 4'b0001, -1);
      next_cycle();
      do_mul(1, 32'd5, 32'd3, 1'b0, 4'b0000, -1);
      next_cycle();

      // Flush in RUN at cycle 10, then no release pulse afterwards.
      do_mul(0, 32'h1234, 32'h5678, 1'b1, 4'b0000, 10);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("post_flush_quiet", {busy[0], result_valid[0], status_we[0]}, 3'b000);
      end

      // Flush in DONE suppresses the release.
      do_mul(0, 32'd9, 32'd9, 1'b1, 4'b0000, 33);
      next_cycle();

      // Flush together with a start: no start.
      drive_cmd(0, exe_pkg::EXE_CMD_MUL, 32'd3, 32'd3, 1'b1, 4'b0000);
      flush[0] = 1'b1;
      #1;
      check("flush_start_stall", stall[0], 1'b0);
      next_cycle();
      in_valid[0] = 1'b0;
      flush[0]    = 1'b0;
      check("flush_start_idle", busy[0], 1'b0);

      // Non-MUL instruction leaves the sequencer idle.
      drive_cmd(0, 4'b0010, 32'd3, 32'd3, 1'b1, 4'b0000);
      #1;
      check("non_mul_stall", stall[0], 1'b0);
      next_cycle();
      check("non_mul_idle", {busy[0], result_valid[0]}, 2'b00);
      in_valid[0] = 1'b0;
      next_cycle();

      // Asynchronous reset at cycle 5 of a RUN, with the MUL still in EXE.
      drive_cmd(0, exe_pkg::EXE_CMD_MUL, 32'd11, 32'd13, 1'b1, 4'b0011);
      repeat (5) next_cycle();
      check("pre_reset_run", {busy[0], stall[0]}, 2'b11);
      rst = 1'b0;
      #1;
      check("async_reset_ctrl", {stall, busy, result_valid, status_we}, '0);
      check("async_reset_data", {result[0], status[0]}, '0);
      in_valid[0] = 1'b0;
      next_cycle();
      rst = 1'b1;
      next_cycle();
      do_mul(0, 32'd11, 32'd13, 1'b1, 4'b0011, -1);
      next_cycle();

      // Back-to-back: second start in the IDLE cycle right after DONE.
      for (int k = 0; k < N; k += 2) begin
         do_mul(k, 32'd3, 32'd4, 1'b1, 4'b0000, -1);
         next_cycle();
         do_mul(k, 32'd5, 32'd5, 1'b1, 4'b0000, -1);
         next_cycle();
      end

      // Randomized operands on every instance.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < N; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            do_mul(k, ra, rb, 1'($urandom_range(0, 1)), 4'($urandom), -1);
            next_cycle();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
